// File: rtl/ioctl_loader_pkg.sv
// Shared types and constants for the ioctl download loader.
package ioctl_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_CART = 8'd1;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ioctl_fifo.sv
// Generic synchronous FIFO; push is ignored when full unless a pop happens in the same cycle.
module ioctl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (do_pop && !do_push) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ioctl_loader.sv
// Packs ioctl download bytes into DW-wide memory writes queued through a small FIFO.
// A byte reaches mem_req two cycles after its strobe; ioctl_wait throttles near FIFO full and in DRAIN.
module ioctl_loader
  import ioctl_loader_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = 8,
  parameter int AW    = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ioctl_download,
  input  logic                     ioctl_wr,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  input  logic [7:0]               ioctl_index,
  output logic                     ioctl_wait,
  output logic                     mem_req,
  output logic [ch_width(NCH)-1:0] mem_ch,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_data,
  output logic [DW/8-1:0]          mem_be,
  input  logic                     mem_ack,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [7:0]               checksum
);
  localparam int CW   = ch_width(NCH);
  localparam int BW   = DW / 8;
  localparam int EW   = CW + AW + DW + BW;
  localparam int CNTW = $clog2(DEPTH) + 1;
  // occupancy counts FIFO entries plus the staging and packer holding registers
  localparam int OW   = CNTW + 1;
  localparam logic [OW-1:0] FULL_LVL = OW'(DEPTH);
  localparam logic [OW-1:0] WAIT_LVL = OW'(DEPTH - 1);
  localparam logic [7:0]    NCH8     = 8'(NCH);

  state_t          state, state_n;
  logic            dl_q, rise, fall, enter_load;
  logic [7:0]      chan;
  logic            stg_vld, stg_vld_n, hld_vld, hld_vld_n;
  logic [AW-1:0]   stg_addr, stg_addr_n, hld_addr, hld_addr_n;
  logic [DW-1:0]   stg_data, stg_data_n, hld_data, hld_data_n;
  logic [BW-1:0]   stg_be, stg_be_n, hld_be, hld_be_n;
  logic [24:0]     waddr;
  logic            lane, in_range, accept, drop_ovf, pop, push, stg_free;
  logic [DW-1:0]   byte_data;
  logic [BW-1:0]   byte_be;
  logic [EW-1:0]   fifo_rdata;
  logic            fifo_empty, fifo_full;
  logic [CNTW-1:0] fifo_count, fifo_count_n;
  logic [OW-1:0]   occ, occ_n;

  assign rise       = ioctl_download && !dl_q;
  assign fall       = !ioctl_download && dl_q;
  assign enter_load = (state == ST_IDLE) && rise;
  assign waddr      = (DW == 16) ? {1'b0, ioctl_addr[24:1]} : ioctl_addr;
  assign lane       = (DW == 16) ? ioctl_addr[0] : 1'b0;
  assign in_range   = (waddr >> AW) == 25'd0;
  assign pop        = mem_ack && !fifo_empty;
  assign push       = stg_vld && (!fifo_full || pop);
  assign stg_free   = !stg_vld || push;
  assign occ        = OW'(fifo_count) + OW'(stg_vld) + OW'(hld_vld);

  always_comb begin
    state_n = state;
    busy    = (state != ST_IDLE);
    done    = (state == ST_DONE);
    case (state)
      ST_IDLE:  if (rise) state_n = ST_LOAD;
      ST_LOAD:  if (fall) state_n = ST_DRAIN;
      ST_DRAIN: if (!hld_vld && !stg_vld && fifo_empty) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_be   = BW'(1) << lane;
    byte_data = '0;
    for (int i = 0; i < BW; i++) byte_data[8*i +: 8] = byte_be[i] ? ioctl_dout : 8'h00;

    accept   = 1'b0;
    drop_ovf = 1'b0;
    if (state == ST_LOAD && ioctl_wr && chan < NCH8) begin
      if (!in_range || occ >= FULL_LVL) drop_ovf = 1'b1;
      else                              accept   = 1'b1;
    end

    stg_vld_n  = stg_vld && !push;
    stg_addr_n = stg_addr;
    stg_data_n = stg_data;
    stg_be_n   = stg_be;
    hld_vld_n  = hld_vld;
    hld_addr_n = hld_addr;
    hld_data_n = hld_data;
    hld_be_n   = hld_be;

    // accept implies room, so the staging register is always free to take a new entry
    if (accept) begin
      if (DW == 8) begin
        stg_vld_n  = 1'b1;
        stg_addr_n = waddr[AW-1:0];
        stg_data_n = byte_data;
        stg_be_n   = byte_be;
      end else if (hld_vld && hld_addr == waddr[AW-1:0] && (hld_be & byte_be) == '0) begin
        stg_vld_n  = 1'b1;
        stg_addr_n = hld_addr;
        stg_data_n = hld_data | byte_data;
        stg_be_n   = hld_be | byte_be;
        hld_vld_n  = 1'b0;
      end else begin
        if (hld_vld) begin
          stg_vld_n  = 1'b1;
          stg_addr_n = hld_addr;
          stg_data_n = hld_data;
          stg_be_n   = hld_be;
        end
        hld_vld_n  = 1'b1;
        hld_addr_n = waddr[AW-1:0];
        hld_data_n = byte_data;
        hld_be_n   = byte_be;
      end
    end else if (state == ST_DRAIN && hld_vld && stg_free) begin
      stg_vld_n  = 1'b1;
      stg_addr_n = hld_addr;
      stg_data_n = hld_data;
      stg_be_n   = hld_be;
      hld_vld_n  = 1'b0;
    end

    fifo_count_n = fifo_count + CNTW'(push) - CNTW'(pop);
    occ_n        = OW'(fifo_count_n) + OW'(stg_vld_n) + OW'(hld_vld_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // a download still high when reset lifts must not look like a new rising edge
      dl_q       <= 1'b1;
      chan       <= '0;
      stg_vld    <= 1'b0;
      stg_addr   <= '0;
      stg_data   <= '0;
      stg_be     <= '0;
      hld_vld    <= 1'b0;
      hld_addr   <= '0;
      hld_data   <= '0;
      hld_be     <= '0;
      ioctl_wait <= 1'b0;
      overflow   <= 1'b0;
      checksum   <= '0;
    end else begin
      dl_q       <= ioctl_download;
      stg_vld    <= stg_vld_n;
      stg_addr   <= stg_addr_n;
      stg_data   <= stg_data_n;
      stg_be     <= stg_be_n;
      hld_vld    <= hld_vld_n;
      hld_addr   <= hld_addr_n;
      hld_data   <= hld_data_n;
      hld_be     <= hld_be_n;
      ioctl_wait <= (state_n == ST_DRAIN) || (occ_n >= WAIT_LVL);
      if (enter_load) begin
        chan     <= ioctl_index;
        overflow <= 1'b0;
        checksum <= '0;
      end else begin
        if (drop_ovf) overflow <= 1'b1;
        if (accept)   checksum <= checksum + ioctl_dout;
      end
    end
  end

  ioctl_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({chan[CW-1:0], stg_addr, stg_data, stg_be}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign mem_req = !fifo_empty;
  assign {mem_ch, mem_addr, mem_data, mem_be} = fifo_empty ? '0 : fifo_rdata;

endmodule

// File: tb/tb_ioctl_loader.sv
// Directed bench: one byte-wide and one 16-bit loader driven by the same download stream.
module tb_ioctl_loader;
  import ioctl_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;

  logic        wait8, req8, ack8, busy8, done8, ovf8;
  logic        ch8;
  logic [11:0] addr8;
  logic [7:0]  data8, sum8;
  logic        be8;

  logic        wait16, req16, ack16, busy16, done16, ovf16;
  logic        ch16;
  logic [11:0] addr16;
  logic [15:0] data16;
  logic [1:0]  be16;
  logic [7:0]  sum16;

  int checks = 0;
  int errors = 0;
  int done8_cnt = 0;
  int done16_cnt = 0;
  int d0;
  int n;
  logic [47:0] q8[$];
  logic [47:0] q16[$];

  always #5 clk = ~clk;

  ioctl_loader #(.NCH(2), .DW(8), .AW(12), .DEPTH(4)) u8 (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(wait8), .mem_req(req8), .mem_ch(ch8), .mem_addr(addr8), .mem_data(data8),
    .mem_be(be8), .mem_ack(ack8), .busy(busy8), .done(done8), .overflow(ovf8), .checksum(sum8)
  );

  ioctl_loader #(.NCH(2), .DW(16), .AW(12), .DEPTH(4)) u16 (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(wait16), .mem_req(req16), .mem_ch(ch16), .mem_addr(addr16), .mem_data(data16),
    .mem_be(be16), .mem_ack(ack16), .busy(busy16), .done(done16), .overflow(ovf16), .checksum(sum16)
  );

  // completed writes recorded as {ch, be, addr, data}, each field zero-padded
  always @(negedge clk) begin
    if (req8 && ack8)   q8.push_back({8'(ch8), 8'(be8), 16'(addr8), 16'(data8)});
    if (req16 && ack16) q16.push_back({8'(ch16), 8'(be16), 16'(addr16), data16});
    if (done8)  done8_cnt++;
    if (done16) done16_cnt++;
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] at8(input int i);
    return (i < q8.size()) ? q8[i] : 48'hFFFF_FFFF_FFFF;
  endfunction

  function automatic logic [47:0] at16(input int i);
    return (i < q16.size()) ? q16[i] : 48'hFFFF_FFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy8 || busy16) && k < 100) begin
      tick();
      k++;
    end
    check(tag, {46'd0, busy8, busy16}, 48'd0);
  endtask

  initial begin
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ioctl_index = '0;
    ack8 = 1'b1;
    ack16 = 1'b1;
    tick();
    tick();
    check("rst_req",  {47'd0, req8}, 48'd0);
    check("rst_wait", {47'd0, wait8}, 48'd0);
    check("rst_busy_done", {46'd0, busy8, done8}, 48'd0);
    check("rst_ovf",  {47'd0, ovf8}, 48'd0);
    check("rst_sum",  {40'd0, sum8}, 48'd0);
    check("rst_mem",  {8'(ch8), 8'(be8), 16'(addr8), 16'(data8)}, 48'd0);
    reset = 1'b0;
    tick();

    // three bytes to channel 1, plus first-byte latency
    q8.delete();
    d0 = done8_cnt;
    start_dl(IDX_CART);
    wr_byte(25'd0, 8'h10);
    check("lat_cycle1", {47'd0, req8}, 48'd0);
    tick();
    check("lat_cycle2", {47'd0, req8}, 48'd1);
    wr_byte(25'd1, 8'h20);
    wr_byte(25'd2, 8'h30);
    end_dl();
    wait_idle("basic_idle");
    check("basic_count", 48'(q8.size()), 48'd3);
    check("basic_w0", at8(0), 48'h01_01_0000_0010);
    check("basic_w1", at8(1), 48'h01_01_0001_0020);
    check("basic_w2", at8(2), 48'h01_01_0002_0030);
    check("basic_sum", {40'd0, sum8}, 48'h60);
    check("basic_done", 48'(done8_cnt - d0), 48'd1);
    check("basic_ovf", {47'd0, ovf8}, 48'd0);

    // 16-bit packing with a trailing odd-length flush
    q16.delete();
    start_dl(IDX_CART);
    wr_byte(25'd0, 8'hAA);
    wr_byte(25'd1, 8'hBB);
    wr_byte(25'd2, 8'hCC);
    end_dl();
    wait_idle("pack_idle");
    check("pack_count", 48'(q16.size()), 48'd2);
    check("pack_w0", at16(0), 48'h01_03_0000_BBAA);
    check("pack_w1", at16(1), 48'h01_01_0001_00CC);
    check("pack_sum", {40'd0, sum16}, 48'h31);

    // backpressure with memory stalled, channel 0
    q8.delete();
    ack8 = 1'b0;
    start_dl(IDX_ROM);
    wr_byte(25'd0, 8'h40);
    wr_byte(25'd1, 8'h41);
    check("wait_low", {47'd0, wait8}, 48'd0);
    wr_byte(25'd2, 8'h42);
    check("wait_high", {47'd0, wait8}, 48'd1);
    wr_byte(25'd3, 8'h43);
    check("wait_slot_ovf", {47'd0, ovf8}, 48'd0);
    tick();
    tick();
    tick();
    check("stall_req", {47'd0, req8}, 48'd1);
    check("stall_nowrite", 48'(q8.size()), 48'd0);
    check("stall_wait", {47'd0, wait8}, 48'd1);
    ack8 = 1'b1;
    n = 4;
    for (int c = 0; c < 40 && n < 6; c++) begin
      if (!wait8) begin
        ioctl_addr = 25'(n);
        ioctl_dout = 8'h40 + 8'(n);
        ioctl_wr   = 1'b1;
        n++;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
    end
    ioctl_wr = 1'b0;
    check("bp_sent", 48'(n), 48'd6);
    end_dl();
    wait_idle("bp_idle");
    check("bp_count", 48'(q8.size()), 48'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("bp_w%0d", i), at8(i), {8'h00, 8'h01, 16'(i), 8'h00, 8'h40 + 8'(i)});
    check("bp_ovf", {47'd0, ovf8}, 48'd0);

    // invalid channel: bytes silently ignored, completion still signalled
    q8.delete();
    d0 = done8_cnt;
    start_dl(8'd5);
    wr_byte(25'd0, 8'h11);
    wr_byte(25'd1, 8'h22);
    end_dl();
    wait_idle("badch_idle");
    check("badch_nowrite", 48'(q8.size()), 48'd0);
    check("badch_ovf", {47'd0, ovf8}, 48'd0);
    check("badch_sum", {40'd0, sum8}, 48'd0);
    check("badch_done", 48'(done8_cnt - d0), 48'd1);

    // out-of-range address sets sticky overflow
    q8.delete();
    start_dl(IDX_CART);
    wr_byte(25'd4096, 8'h77);
    check("range_ovf", {47'd0, ovf8}, 48'd1);
    wr_byte(25'd3, 8'h05);
    end_dl();
    wait_idle("range_idle");
    check("range_sticky", {47'd0, ovf8}, 48'd1);
    check("range_count", 48'(q8.size()), 48'd1);
    check("range_w0", at8(0), 48'h01_01_0003_0005);
    check("range_sum", {40'd0, sum8}, 48'h05);

    // reset with two writes queued
    ack8 = 1'b0;
    start_dl(IDX_CART);
    check("range_clear", {47'd0, ovf8}, 48'd0);
    wr_byte(25'd8, 8'h81);
    wr_byte(25'd9, 8'h82);
    tick();
    check("queued_req", {46'd0, req8, busy8}, 48'd3);
    q8.delete();
    #2;
    reset = 1'b1;
    #1;
    check("arst_req", {47'd0, req8}, 48'd0);
    check("arst_busy", {47'd0, busy8}, 48'd0);
    tick();
    reset = 1'b0;
    ack8 = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("post_rst_nowrite", 48'(q8.size()), 48'd0);
    check("post_rst_idle", {46'd0, busy8, req8}, 48'd0);
    ioctl_download = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
